// File: rtl/src_pixel_pack_if.sv
// Source byte stream in, packed pixel stream out. The master side drives the source
// video signals; the slave side is the packer.
interface src_pixel_pack_if #(
  parameter int unsigned SRC_DW  = 8,
  parameter int unsigned SRC_CHN = 3
) ();
  logic                       src_hsync;
  logic                       src_vsync;
  logic [SRC_DW-1:0]          src_data_in;
  logic                       pix_hsync;
  logic                       pix_vsync;
  logic                       pix_de;
  logic [SRC_DW*SRC_CHN-1:0]  pix_data;
  logic [11:0]                pix_x;
  logic [11:0]                pix_y;
  logic [15:0]                frame_cnt;
  logic [1:0]                 err;

  modport master (
    output src_hsync, src_vsync, src_data_in,
    input  pix_hsync, pix_vsync, pix_de, pix_data, pix_x, pix_y, frame_cnt, err
  );

  modport slave (
    input  src_hsync, src_vsync, src_data_in,
    output pix_hsync, pix_vsync, pix_de, pix_data, pix_x, pix_y, frame_cnt, err
  );
endinterface

// File: rtl/src_pixel_pack.sv
// Packs a byte-serial multi-channel video stream into parallel pixels with coordinates,
// a frame counter and sticky line framing errors.
module src_pixel_pack #(
  parameter int unsigned IW      = 640,
  parameter int unsigned IH      = 480,
  parameter int unsigned SRC_DW  = 8,
  parameter int unsigned SRC_CHN = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  src_pixel_pack_if.slave bus
);
  localparam int unsigned PW = SRC_DW * SRC_CHN;
  localparam int unsigned AW = PW - SRC_DW;
  localparam int unsigned CW = (SRC_CHN > 1) ? $clog2(SRC_CHN) : 1;
  localparam logic [CW-1:0] ChnLast = CW'(SRC_CHN - 1);
  localparam logic [11:0]   LineLen = 12'(IW);

  if (SRC_CHN < 2 || IW < 1 || IW > 4095 || IH < 1) begin : g_bad_params
    $error("src_pixel_pack: unsupported parameter set");
  end

  // Arming: after reset, wait for hsync to be seen low and then high so a reset
  // released mid-line never starts packing on a misaligned byte.
  typedef enum logic [1:0] {StIdle, StSync, StArmed} state_e;

  state_e         state_q, state_d;
  logic           hsync_q, vsync_q;
  logic [CW-1:0]  chn_q, chn_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [11:0]    x_cnt_q, x_cnt_d;
  logic [11:0]    line_cnt_q, line_cnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]     err_q, err_d;
  logic           pix_de_q, pix_de_d;
  logic [PW-1:0]  pix_data_q, pix_data_d;
  logic [11:0]    pix_x_q, pix_x_d;
  logic [11:0]    pix_y_q, pix_y_d;

  logic hs_fall, vs_rise, armed_now, run;

  assign hs_fall   = hsync_q & ~bus.src_hsync;
  assign vs_rise   = bus.src_vsync & ~vsync_q;
  assign armed_now = (state_q == StArmed) || (state_q == StSync && bus.src_hsync);
  assign run       = bus.src_hsync & bus.src_vsync & armed_now;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!bus.src_hsync) state_d = StSync;
      StSync:  if (bus.src_hsync)  state_d = StArmed;
      StArmed: state_d = StArmed;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    chn_d       = chn_q;
    acc_d       = acc_q;
    x_cnt_d     = x_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    pix_de_d    = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;

    if (vs_rise) begin
      // Frame start outranks a coincident line end; that line's errors are dropped.
      chn_d       = '0;
      x_cnt_d     = '0;
      line_cnt_d  = '0;
      err_d       = '0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      if (hs_fall && state_q == StArmed) begin
        if (chn_q != '0)       err_d[0] = 1'b1;
        if (x_cnt_q != LineLen) err_d[1] = 1'b1;
        if (x_cnt_q != '0)     line_cnt_d = line_cnt_q + 12'd1;
        x_cnt_d = '0;
        chn_d   = '0;
      end else if (run) begin
        acc_d = AW'({acc_q, bus.src_data_in});
        if (chn_q == ChnLast) begin
          pix_de_d   = 1'b1;
          pix_data_d = {acc_q, bus.src_data_in};
          pix_x_d    = x_cnt_q;
          pix_y_d    = line_cnt_q;
          x_cnt_d    = x_cnt_q + 12'd1;
          chn_d      = '0;
        end else begin
          chn_d = chn_q + CW'(1);
        end
      end
      if (!bus.src_vsync) begin
        chn_d   = '0;
        x_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      chn_q       <= '0;
      acc_q       <= '0;
      x_cnt_q     <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
      pix_de_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      hsync_q     <= bus.src_hsync;
      vsync_q     <= bus.src_vsync;
      chn_q       <= chn_d;
      acc_q       <= acc_d;
      x_cnt_q     <= x_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      pix_de_q    <= pix_de_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

  assign bus.pix_hsync = hsync_q;
  assign bus.pix_vsync = vsync_q;
  assign bus.pix_de    = pix_de_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_src_pixel_pack.sv
// Scoreboard bench for src_pixel_pack: stimulus pushes expected pixels, a negedge
// monitor pops and compares on every pix_de.
module tb_src_pixel_pack;
  localparam int unsigned IW  = 640;
  localparam int unsigned IH  = 480;
  localparam int unsigned DW  = 8;
  localparam int unsigned CHN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  src_pixel_pack_if #(.SRC_DW(DW), .SRC_CHN(CHN)) bus ();

  src_pixel_pack #(
    .IW(IW), .IH(IH), .SRC_DW(DW), .SRC_CHN(CHN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic [11:0] x;
    logic [11:0] y;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pix_de must match the oldest expected pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pix_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pix_de: got pixel 0x%0h x=%0d y=%0d, want no pixel",
                   bus.pix_data, bus.pix_x, bus.pix_y);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", 32'(bus.pix_data), 32'(mon_e.data));
          chk("pix_x", 32'(bus.pix_x), 32'(mon_e.x));
          chk("pix_y", 32'(bus.pix_y), 32'(mon_e.y));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.src_hsync   = 1'b1;
    bus.src_data_in = b;
    step();
  endtask

  task automatic idle(input int n);
    bus.src_hsync   = 1'b0;
    bus.src_data_in = '0;
    repeat (n) step();
  endtask

  // Sends nbytes; every completed triple is expected as pixel (x = i/3, y).
  task automatic send_line(input int nbytes, input int y, input logic [7:0] seed);
    logic [23:0] acc;
    logic [7:0]  b;
    pix_t        p;
    acc = '0;
    for (int i = 0; i < nbytes; i++) begin
      b   = seed + 8'(i * 5);
      acc = {acc[15:0], b};
      if (i % 3 == 2) begin
        p.data = acc;
        p.x    = 12'(i / 3);
        p.y    = 12'(y);
        exp_q.push_back(p);
      end
      put(b);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_de"}, 32'(bus.pix_de), 0);
    chk({tag, "_pix_data"}, 32'(bus.pix_data), 0);
    chk({tag, "_pix_x"}, 32'(bus.pix_x), 0);
    chk({tag, "_pix_y"}, 32'(bus.pix_y), 0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_pix_hsync"}, 32'(bus.pix_hsync), 0);
  endtask

  pix_t p0;

  initial begin
    bus.src_hsync   = 1'b0;
    bus.src_vsync   = 1'b0;
    bus.src_data_in = '0;
    rst_n           = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_pix_vsync", 32'(bus.pix_vsync), 0);
    rst_n = 1'b1;
    step();
    idle(2);

    // Lines during vertical sync produce no pixels.
    repeat (2) begin
      for (int i = 0; i < 6; i++) put(8'hA0 + 8'(i));
      idle(3);
    end

    // Three frame starts; pix_vsync lags by one cycle.
    for (int k = 1; k <= 3; k++) begin
      bus.src_vsync = 1'b0;
      idle(2);
      bus.src_vsync = 1'b1;
      @(negedge clk);
      chk("pix_vsync_before_edge", 32'(bus.pix_vsync), 0);
      step();
      @(negedge clk);
      chk("pix_vsync_after_edge", 32'(bus.pix_vsync), 1);
      chk("frame_cnt_count", 32'(bus.frame_cnt), k);
      step();
    end
    chk("err_cleared_by_frame", 32'(bus.err), 0);

    // Single pixel 0x11,0x22,0x33.
    put(8'h11);
    put(8'h22);
    p0.data = 24'h112233;
    p0.x    = '0;
    p0.y    = '0;
    exp_q.push_back(p0);
    put(8'h33);
    bus.src_hsync = 1'b0;
    @(negedge clk);
    chk("single_pix_de", 32'(bus.pix_de), 1);
    chk("single_err", 32'(bus.err), 0);
    step();
    @(negedge clk);
    chk("single_pix_de_width", 32'(bus.pix_de), 0);
    chk("single_err_len", 32'(bus.err), 2);
    step();
    idle(2);

    bus.src_vsync = 1'b0;
    idle(2);
    bus.src_vsync = 1'b1;
    idle(2);
    @(negedge clk);
    chk("reframe_frame_cnt", 32'(bus.frame_cnt), 4);
    chk("reframe_err", 32'(bus.err), 0);
    step();

    // Full-length lines.
    for (int y = 0; y < 3; y++) begin
      send_line(3 * IW, y, 8'(y * 3 + 1));
      bus.src_hsync = 1'b0;
      @(negedge clk);
      chk("full_last_pix_x", 32'(bus.pix_x), IW - 1);
      chk("full_pix_y", 32'(bus.pix_y), y);
      step();
      idle(2);
      @(negedge clk);
      chk("full_err", 32'(bus.err), 0);
      step();
    end

    // Short line of 7 bytes.
    send_line(7, 3, 8'h40);
    idle(3);
    @(negedge clk);
    chk("short_err", 32'(bus.err), 3);
    step();
    bus.src_vsync = 1'b0;
    idle(1);
    bus.src_vsync = 1'b1;
    idle(2);
    @(negedge clk);
    chk("short_err_cleared", 32'(bus.err), 0);
    chk("short_frame_cnt", 32'(bus.frame_cnt), 5);
    step();

    // Line end on the same edge as a frame start, with a partial pixel pending.
    send_line(4, 0, 8'h80);
    bus.src_vsync = 1'b0;
    put(8'h99);
    bus.src_vsync = 1'b1;
    idle(1);
    @(negedge clk);
    chk("coincide_err", 32'(bus.err), 0);
    chk("coincide_frame_cnt", 32'(bus.frame_cnt), 6);
    step();
    send_line(3, 0, 8'hC0);
    idle(3);

    // Reset in the middle of a line.
    send_line(4, 1, 8'h10);
    rst_n = 1'b0;
    put(8'hEE);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    step();
    for (int i = 0; i < 6; i++) put(8'h50 + 8'(i));
    idle(3);
    send_line(6, 0, 8'h60);
    idle(4);

    @(negedge clk);
    chk("pending_pixels", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
